// File: rtl/mdu_ctrl_pkg.sv
// Shared types and op codes for the EX-stage multiply/divide sequencer.
package mdu_ctrl_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned OP_W  = 5;

  localparam logic [OP_W-1:0] OP_MULT  = 5'd1;
  localparam logic [OP_W-1:0] OP_MULTU = 5'd2;
  localparam logic [OP_W-1:0] OP_DIV   = 5'd3;
  localparam logic [OP_W-1:0] OP_DIVU  = 5'd4;
  localparam logic [OP_W-1:0] OP_MTHI  = 5'd5;
  localparam logic [OP_W-1:0] OP_MTLO  = 5'd6;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL_WAIT = 2'd1,
    S_DIV_RUN  = 2'd2,
    S_DONE     = 2'd3
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } mdu_req_t;

  typedef struct packed {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
  } mdu_res_t;

  function automatic logic is_mul(input logic [OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_div(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_ctrl_div_radix2.sv
// Iterative restoring radix-2 divider: one quotient bit per cycle, WIDTH iterations.
module mdu_ctrl_div_radix2
  import mdu_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             cancel_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_c_o,
  output logic [WIDTH-1:0] quot_c_o,
  output logic [WIDTH-1:0] rem_c_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [WIDTH-1:0]   abs_a, abs_b;

  // Partial remainder layout: {remainder, dividend bits shifting out / quotient bits shifting in}.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] pr,
                                                  input logic [WIDTH-1:0]   d);
    logic [WIDTH:0] top;
    logic           qbit;
    top  = pr[2*WIDTH-1:WIDTH-1];
    qbit = (top >= {1'b0, d});
    if (qbit) top = top - {1'b0, d};
    return {top[WIDTH-1:0], pr[WIDTH-2:0], qbit};
  endfunction

  assign abs_a = (signed_i && a_i[WIDTH-1]) ? (-a_i) : a_i;
  assign abs_b = (signed_i && b_i[WIDTH-1]) ? (-b_i) : b_i;

  // The first iteration is folded into the start edge so the result is ready after WIDTH cycles.
  always_comb begin
    cnt_d  = cnt_q;
    prem_d = prem_q;
    dvs_d  = dvs_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    if (cancel_i) begin
      cnt_d = '0;
    end else if (start_i) begin
      dvs_d  = abs_b;
      qneg_d = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      rneg_d = signed_i & a_i[WIDTH-1];
      prem_d = div_step({{WIDTH{1'b0}}, abs_a}, abs_b);
      cnt_d  = CNT_W'(1);
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else if (cnt_q != '0) begin
      prem_d = div_step(prem_q, dvs_q);
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      prem_q <= '0;
      dvs_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      prem_q <= prem_d;
      dvs_q  <= dvs_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
  end

  assign done_c_o = (cnt_q == CNT_LAST);
  assign quot_c_o = qneg_q ? (-prem_q[WIDTH-1:0]) : prem_q[WIDTH-1:0];
  assign rem_c_o  = rneg_q ? (-prem_q[2*WIDTH-1:WIDTH]) : prem_q[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/mdu_ctrl.sv
// EX-stage multiply/divide sequencer: owns HI/LO, times the multiplier window, runs the divider.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid_i,
  input  logic [OP_W-1:0]  op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             stall_c_o,
  output logic             busy_o
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mdu_req_t         req_q, req_d;
  mdu_res_t         res_q, res_d;
  logic             no_wr_q, no_wr_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;

  logic               accept;
  logic               div_start, div_cancel, div_done;
  logic [WIDTH-1:0]   div_quot, div_rem;
  logic               mul_sext;
  logic [2*WIDTH-1:0] mul_a, mul_b, mul_res;

  // Sign-extending for MULT makes the truncated 2*WIDTH product the signed result.
  assign mul_sext = (req_q.op == OP_MULT);
  assign mul_a    = {{WIDTH{mul_sext & req_q.a[WIDTH-1]}}, req_q.a};
  assign mul_b    = {{WIDTH{mul_sext & req_q.b[WIDTH-1]}}, req_q.b};
  assign mul_res  = mul_a * mul_b;

  mdu_ctrl_div_radix2 u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (div_start),
    .cancel_i (div_cancel),
    .signed_i (op_i == OP_DIV),
    .a_i      (a_i),
    .b_i      (b_i),
    .done_c_o (div_done),
    .quot_c_o (div_quot),
    .rem_c_o  (div_rem)
  );

  assign accept = op_valid_i & ~flush_i;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    res_d      = res_q;
    no_wr_d    = no_wr_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    stall_c_o  = 1'b0;
    div_start  = 1'b0;
    div_cancel = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_mul(op_i)) begin
            req_d     = '{op: op_i, a: a_i, b: b_i};
            cnt_d     = MUL_LAST;
            no_wr_d   = 1'b0;
            stall_c_o = 1'b1;
            state_d   = S_MUL_WAIT;
          end else if (is_div(op_i)) begin
            req_d     = '{op: op_i, a: a_i, b: b_i};
            stall_c_o = 1'b1;
            if (b_i == '0) begin
              no_wr_d = 1'b1;
              state_d = S_DONE;
            end else begin
              no_wr_d   = 1'b0;
              div_start = 1'b1;
              state_d   = S_DIV_RUN;
            end
          end else if (op_i == OP_MTHI) begin
            hi_d = a_i;
          end else if (op_i == OP_MTLO) begin
            lo_d = a_i;
          end
        end
      end
      S_MUL_WAIT: begin
        stall_c_o = 1'b1;
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          res_d   = mul_res;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DIV_RUN: begin
        stall_c_o = 1'b1;
        if (flush_i) begin
          div_cancel = 1'b1;
          state_d    = S_IDLE;
        end else if (div_done) begin
          res_d   = '{hi: div_rem, lo: div_quot};
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!flush_i && !no_wr_q) begin
          hi_d = res_q.hi;
          lo_d = res_q.lo;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_d = (state_d != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      res_q   <= '0;
      no_wr_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      res_q   <= res_d;
      no_wr_q <= no_wr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl with MUL_CYCLES=2.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid;
  logic [4:0]  op;
  logic [31:0] a, b;
  logic        flush;
  logic [31:0] hi, lo;
  logic        stall_c;
  logic        busy;

  int n_pass   = 0;
  int n_checks = 0;

  localparam logic [4:0] C_MULT  = 5'd1;
  localparam logic [4:0] C_MULTU = 5'd2;
  localparam logic [4:0] C_DIV   = 5'd3;
  localparam logic [4:0] C_DIVU  = 5'd4;
  localparam logic [4:0] C_MTHI  = 5'd5;
  localparam logic [4:0] C_MTLO  = 5'd6;

  mdu_ctrl #(.MUL_CYCLES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_valid_i (op_valid),
    .op_i       (op),
    .a_i        (a),
    .b_i        (b),
    .flush_i    (flush),
    .hi_o       (hi),
    .lo_o       (lo),
    .stall_c_o  (stall_c),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Present an op as a frozen pipeline would: hold it until stall drops, then one more cycle.
  task automatic run_op(input logic [4:0] opv, input logic [31:0] av, input logic [31:0] bv,
                        output int stalls);
    @(negedge clk);
    op_valid = 1'b1; op = opv; a = av; b = bv;
    #1;
    stalls = 0;
    while (stall_c && stalls < 200) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    op_valid = 1'b0;
    #1;
  endtask

  int n;

  initial begin
    rst_n = 1'b0; op_valid = 1'b0; op = '0; a = '0; b = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_stall", 32'(stall_c), 32'h0);
    rst_n = 1'b1;

    run_op(C_MULT, 32'hFFFF_FFFD, 32'd5, n);
    check("mult_stall", 32'(n), 32'd3);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFF1);

    run_op(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

    run_op(C_MTHI, 32'h1234_5678, 32'h0, n);
    check("mthi_stall", 32'(n), 32'd0);
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_lo", lo, 32'h0000_0001);
    run_op(C_MTLO, 32'hCAFE_F00D, 32'h0, n);
    check("mtlo_lo", lo, 32'hCAFE_F00D);

    run_op(C_DIV, 32'd7, 32'hFFFF_FFFE, n);
    check("div_stall", 32'(n), 32'd33);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'h0000_0001);

    run_op(C_DIVU, 32'd7, 32'hFFFF_FFFE, n);
    check("divu_lo", lo, 32'h0);
    check("divu_hi", hi, 32'd7);

    run_op(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
    check("divovf_stall", 32'(n), 32'd33);
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'h0);

    run_op(C_MTHI, 32'hAAAA_5555, 32'h0, n);
    run_op(C_MTLO, 32'h5555_AAAA, 32'h0, n);
    run_op(C_DIV, 32'd9, 32'h0, n);
    check("div0_stall", 32'(n), 32'd1);
    check("div0_hi", hi, 32'hAAAA_5555);
    check("div0_lo", lo, 32'h5555_AAAA);

    // Flush during the 10th DIV_RUN cycle.
    @(negedge clk);
    op_valid = 1'b1; op = C_DIV; a = 32'd7; b = 32'hFFFF_FFFE;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flushdiv_busy_before", 32'(busy), 32'h1);
    @(negedge clk);
    flush = 1'b0; op_valid = 1'b0;
    #1;
    check("flushdiv_stall", 32'(stall_c), 32'h0);
    check("flushdiv_busy", 32'(busy), 32'h0);
    repeat (2) @(negedge clk);
    check("flushdiv_hi", hi, 32'hAAAA_5555);
    check("flushdiv_lo", lo, 32'h5555_AAAA);

    // Flush in the DONE cycle of a MULT.
    @(negedge clk);
    op_valid = 1'b1; op = C_MULT; a = 32'd6; b = 32'd7;
    #1;
    n = 0;
    while (stall_c && n < 20) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("flushdone_stall", 32'(n), 32'd3);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; op_valid = 1'b0;
    #1;
    check("flushdone_hi", hi, 32'hAAAA_5555);
    check("flushdone_lo", lo, 32'h5555_AAAA);
    check("flushdone_busy", 32'(busy), 32'h0);

    // Unknown op code is ignored.
    @(negedge clk);
    op_valid = 1'b1; op = 5'd31; a = 32'h1111_1111; b = 32'd3;
    #1;
    check("unk_stall", 32'(stall_c), 32'h0);
    @(negedge clk);
    op_valid = 1'b0;
    #1;
    check("unk_busy", 32'(busy), 32'h0);
    check("unk_hi", hi, 32'hAAAA_5555);

    // Flush in IDLE blocks MTHI.
    @(negedge clk);
    op_valid = 1'b1; op = C_MTHI; a = 32'hDEAD_BEEF; flush = 1'b1;
    #1;
    check("idleflush_stall", 32'(stall_c), 32'h0);
    @(negedge clk);
    op_valid = 1'b0; flush = 1'b0;
    #1;
    check("idleflush_hi", hi, 32'hAAAA_5555);

    run_op(C_DIVU, 32'd100, 32'd7, n);
    check("divu100_lo", lo, 32'd14);
    check("divu100_hi", hi, 32'd2);
    run_op(C_DIV, 32'hFFFF_FF9C, 32'd7, n);
    check("divneg_lo", lo, 32'hFFFF_FFF2);
    check("divneg_hi", hi, 32'hFFFF_FFFE);

    // Async reset in the middle of a divide.
    @(negedge clk);
    op_valid = 1'b1; op = C_DIVU; a = 32'd100; b = 32'd7;
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    op_valid = 1'b0;
    #1;
    check("midrst_hi", hi, 32'h0);
    check("midrst_lo", lo, 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(C_MULT, 32'd3, 32'd5, n);
    check("postrst_stall", 32'(n), 32'd3);
    check("postrst_hi", hi, 32'h0);
    check("postrst_lo", lo, 32'd15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
